// File: rtl/mouse_init_sequencer_if.sv
// Byte-level link between the mouse init sequencer and the PS/2 tx/rx units.
// The master side is the sequencer, and the slave side is the PS/2 serialiser pair.
interface mouse_init_sequencer_if;
  logic       tx_idle;
  logic       tx_done_tick;
  logic       rx_done_tick;
  logic [7:0] rx_data;
  logic       wr_ps2;
  logic [7:0] din;

  modport master (
    input  tx_idle, tx_done_tick, rx_done_tick, rx_data,
    output wr_ps2, din
  );

  modport slave (
    output tx_idle, tx_done_tick, rx_done_tick, rx_data,
    input  wr_ps2, din
  );
endinterface

// File: rtl/mouse_init_sequencer.sv
// PS/2 mouse power-up sequencer: FF reset, BAT/ID check, optional sample rate, F4 enable.
// Define MOUSE_SAMPLE_RATE_EN to send F3 <SAMPLE_RATE> between the ID check and F4.
module mouse_init_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 25_000_000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter logic [7:0]  SAMPLE_RATE    = 8'd100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reinit,
  mouse_init_sequencer_if.master ps2,
  output logic                   stream_en,
  output logic                   init_error,
  output logic [1:0]             retry_cnt,
  output logic [3:0]             state_dbg
);

  localparam int unsigned TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [1:0]         RETRY_LIMIT = 2'(MAX_RETRIES);

  localparam logic [7:0] BYTE_RESET    = 8'hFF;
  localparam logic [7:0] BYTE_SET_RATE = 8'hF3;
  localparam logic [7:0] BYTE_ENABLE   = 8'hF4;
  localparam logic [7:0] BYTE_ACK      = 8'hFA;
  localparam logic [7:0] BYTE_RESEND   = 8'hFE;
  localparam logic [7:0] BYTE_BAT_OK   = 8'hAA;
  localparam logic [7:0] BYTE_MOUSE_ID = 8'h00;

  typedef enum logic [3:0] {
    S_SEND_RST     = 4'd0,
    S_WAIT_ACK_RST = 4'd1,
    S_WAIT_BAT     = 4'd2,
    S_WAIT_ID      = 4'd3,
    S_SEND_SR      = 4'd4,
    S_WAIT_ACK_SR  = 4'd5,
    S_SEND_SRV     = 4'd6,
    S_WAIT_ACK_SRV = 4'd7,
    S_SEND_EN      = 4'd8,
    S_WAIT_ACK_EN  = 4'd9,
    S_STREAM       = 4'd10,
    S_ERROR        = 4'd11
  } state_t;

  state_t               state, state_nxt;
  logic [TIMER_W-1:0]   timer, timer_nxt;
  logic                 tx_pend, tx_pend_nxt;
  logic [1:0]           retry_nxt;
  logic                 wr_nxt;
  logic [7:0]           din_nxt;

  // per-state decode: byte to send, expected reply, success and resend targets
  logic                 is_send, is_wait, is_ack_wait;
  logic [7:0]           tx_byte, expect_byte;
  state_t               state_adv, state_rsnd;
  logic                 restart;

  always_comb begin
    is_send     = 1'b0;
    is_wait     = 1'b0;
    is_ack_wait = 1'b0;
    tx_byte     = 8'h00;
    expect_byte = BYTE_ACK;
    state_adv   = S_SEND_RST;
    state_rsnd  = S_SEND_RST;
    case (state)
      S_SEND_RST:     begin is_send = 1'b1; tx_byte = BYTE_RESET;    state_adv = S_WAIT_ACK_RST; end
      S_SEND_SR:      begin is_send = 1'b1; tx_byte = BYTE_SET_RATE; state_adv = S_WAIT_ACK_SR;  end
      S_SEND_SRV:     begin is_send = 1'b1; tx_byte = SAMPLE_RATE;   state_adv = S_WAIT_ACK_SRV; end
      S_SEND_EN:      begin is_send = 1'b1; tx_byte = BYTE_ENABLE;   state_adv = S_WAIT_ACK_EN;  end
      S_WAIT_ACK_RST: begin
        is_wait = 1'b1; is_ack_wait = 1'b1; state_adv = S_WAIT_BAT; state_rsnd = S_SEND_RST;
      end
      S_WAIT_BAT:     begin is_wait = 1'b1; expect_byte = BYTE_BAT_OK; state_adv = S_WAIT_ID; end
      S_WAIT_ID:      begin
        is_wait     = 1'b1;
        expect_byte = BYTE_MOUSE_ID;
`ifdef MOUSE_SAMPLE_RATE_EN
        state_adv   = S_SEND_SR;
`else
        state_adv   = S_SEND_EN;
`endif
      end
      S_WAIT_ACK_SR:  begin
        is_wait = 1'b1; is_ack_wait = 1'b1; state_adv = S_SEND_SRV; state_rsnd = S_SEND_SR;
      end
      S_WAIT_ACK_SRV: begin
        is_wait = 1'b1; is_ack_wait = 1'b1; state_adv = S_SEND_EN; state_rsnd = S_SEND_SRV;
      end
      S_WAIT_ACK_EN:  begin
        is_wait = 1'b1; is_ack_wait = 1'b1; state_adv = S_STREAM; state_rsnd = S_SEND_EN;
      end
      default: ;
    endcase
  end

  // next-state and registered-output values; reinit overrides everything
  always_comb begin
    state_nxt   = state;
    timer_nxt   = '0;
    tx_pend_nxt = tx_pend;
    retry_nxt   = retry_cnt;
    wr_nxt      = 1'b0;
    din_nxt     = ps2.din;
    restart     = 1'b0;

    if (reinit) begin
      state_nxt   = S_SEND_RST;
      tx_pend_nxt = 1'b0;
      retry_nxt   = 2'd0;
    end else if (is_send) begin
      if (!tx_pend && ps2.tx_idle) begin
        wr_nxt      = 1'b1;
        din_nxt     = tx_byte;
        tx_pend_nxt = 1'b1;
      end else if (tx_pend && ps2.tx_done_tick) begin
        state_nxt   = state_adv;
        tx_pend_nxt = 1'b0;
      end
    end else if (is_wait) begin
      timer_nxt = timer + TIMER_W'(1);
      if (ps2.rx_done_tick) begin
        if (ps2.rx_data == expect_byte) begin
          state_nxt = state_adv;
          timer_nxt = '0;
        end else if (is_ack_wait && ps2.rx_data == BYTE_RESEND) begin
          state_nxt = state_rsnd;
          timer_nxt = '0;
        end else begin
          restart = 1'b1;
        end
      end else if (timer == TIMER_LAST) begin
        restart = 1'b1;
      end
    end else if (state != S_STREAM && state != S_ERROR) begin
      // unused encodings fall back to a fresh sequence
      state_nxt = S_SEND_RST;
    end

    if (restart) begin
      timer_nxt = '0;
      if (retry_cnt == RETRY_LIMIT) begin
        state_nxt = S_ERROR;
      end else begin
        state_nxt = S_SEND_RST;
        retry_nxt = retry_cnt + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_SEND_RST;
      timer      <= '0;
      tx_pend    <= 1'b0;
      retry_cnt  <= 2'd0;
      ps2.wr_ps2 <= 1'b0;
      ps2.din    <= 8'h00;
      stream_en  <= 1'b0;
      init_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      timer      <= timer_nxt;
      tx_pend    <= tx_pend_nxt;
      retry_cnt  <= retry_nxt;
      ps2.wr_ps2 <= wr_nxt;
      ps2.din    <= din_nxt;
      stream_en  <= (state_nxt == S_STREAM);
      init_error <= (state_nxt == S_ERROR);
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mouse_init_sequencer.sv
// Directed bench for mouse_init_sequencer: table of reply steps plus timeout/error/reinit/reset sequences.
// Follows the MOUSE_SAMPLE_RATE_EN build setting for the expected command bytes.
module tb_mouse_init_sequencer;

  localparam int unsigned TO = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       reinit = 1'b0;
  logic       stream_en, init_error;
  logic [1:0] retry_cnt;
  logic [3:0] state_dbg;

  mouse_init_sequencer_if ps2();

  mouse_init_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES   (3),
    .SAMPLE_RATE   (8'd100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .reinit    (reinit),
    .ps2       (ps2),
    .stream_en (stream_en),
    .init_error(init_error),
    .retry_cnt (retry_cnt),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // tx unit model: takes a byte on wr_ps2, shifts for 4 cycles, pulses tx_done_tick
  int         tx_busy = 0;
  int         wr_hi   = 0;
  int         dbl_wr  = 0;
  int         din_bad = 0;
  logic [7:0] din_at_wr;
  logic [7:0] wr_log[$];
  int         wr_seen = 0;

  always @(negedge clk) begin
    ps2.tx_done_tick = 1'b0;
    if (ps2.wr_ps2 === 1'b1) wr_hi++; else wr_hi = 0;
    if (wr_hi > 1) dbl_wr++;
    if (!rst) begin
      tx_busy     = 0;
      ps2.tx_idle = 1'b1;
    end else if (tx_busy > 0) begin
      if (ps2.wr_ps2 === 1'b1) dbl_wr++;
      if (ps2.din !== din_at_wr) din_bad++;
      tx_busy--;
      if (tx_busy == 0) begin
        ps2.tx_done_tick = 1'b1;
        ps2.tx_idle      = 1'b1;
      end
    end else if (ps2.wr_ps2 === 1'b1) begin
      tx_busy     = 4;
      ps2.tx_idle = 1'b0;
      din_at_wr   = ps2.din;
      wr_log.push_back(ps2.din);
    end
  end

  typedef struct packed {
    logic       do_reinit;
    logic       do_rx;
    logic [7:0] rx;
    logic [3:0] exp_state;
    logic       exp_stream;
    logic       exp_error;
    logic [1:0] exp_retry;
    logic       exp_wr;
    logic [7:0] exp_din;
    logic [3:0] exp_state_tx;
  } step_t;

  step_t vec[$];

  function automatic step_t mk(logic ri, logic rv, logic [7:0] rx, logic [3:0] st, logic se,
                               logic er, logic [1:0] rc, logic wr, logic [7:0] d, logic [3:0] sttx);
    step_t s;
    s.do_reinit = ri;  s.do_rx = rv;  s.rx = rx;  s.exp_state = st;  s.exp_stream = se;
    s.exp_error = er;  s.exp_retry = rc;  s.exp_wr = wr;  s.exp_din = d;  s.exp_state_tx = sttx;
    return s;
  endfunction

  // reply 00 to the ID wait and acknowledge everything up to the F4 being sent
  task automatic push_id(input logic [1:0] rc);
`ifdef MOUSE_SAMPLE_RATE_EN
    vec.push_back(mk(1'b0, 1'b1, 8'h00, 4'd4, 1'b0, 1'b0, rc, 1'b1, 8'hF3, 4'd5));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd6, 1'b0, 1'b0, rc, 1'b1, 8'h64, 4'd7));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd8, 1'b0, 1'b0, rc, 1'b1, 8'hF4, 4'd9));
`else
    vec.push_back(mk(1'b0, 1'b1, 8'h00, 4'd8, 1'b0, 1'b0, rc, 1'b1, 8'hF4, 4'd9));
`endif
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // wait for the next written byte, check it, then check the state once it is shifted out
  task automatic expect_write(input string nm, input logic [7:0] b, input logic [3:0] st_after);
    int n = 0;
    while (wr_log.size() <= wr_seen && n < 300) begin step(); n++; end
    if (wr_log.size() <= wr_seen) begin
      chk({nm, "_wr_count"}, 32'(wr_log.size()), 32'(wr_seen + 1));
      return;
    end
    chk({nm, "_din"}, 32'(wr_log[wr_seen]), 32'(b));
    wr_seen++;
    n = 0;
    while (ps2.tx_done_tick !== 1'b1 && n < 20) begin step(); n++; end
    step();
    chk({nm, "_st_tx"}, 32'(state_dbg), 32'(st_after));
  endtask

  task automatic apply_step(input string nm, input step_t s);
    if (s.do_reinit) reinit = 1'b1;
    if (s.do_rx) begin
      ps2.rx_data      = s.rx;
      ps2.rx_done_tick = 1'b1;
    end
    step();
    reinit           = 1'b0;
    ps2.rx_done_tick = 1'b0;
    chk({nm, "_state"},  32'(state_dbg),  32'(s.exp_state));
    chk({nm, "_stream"}, 32'(stream_en),  32'(s.exp_stream));
    chk({nm, "_error"},  32'(init_error), 32'(s.exp_error));
    chk({nm, "_retry"},  32'(retry_cnt),  32'(s.exp_retry));
    if (s.exp_wr) expect_write(nm, s.exp_din, s.exp_state_tx);
  endtask

  task automatic pulse_reinit();
    reinit = 1'b1;
    step();
    reinit = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog state=%0d", state_dbg);
    $fatal(1);
  end

  initial begin
    int n;
    int gap;

    ps2.rx_done_tick = 1'b0;
    ps2.rx_data      = 8'h00;

    // nominal, rx ignored in STREAM, reinit in STREAM, rx dropped in SEND_RST
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hAA, 4'd3,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    push_id(2'd0);
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 2'd0, 1'b1, 8'hFF, 4'd1));
    // NAK on F4: resend without counting a retry
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hAA, 4'd3,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    push_id(2'd0);
    vec.push_back(mk(1'b0, 1'b1, 8'hFE, 4'd8,  1'b0, 1'b0, 2'd0, 1'b1, 8'hF4, 4'd9));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b1, 1'b0, 8'h00, 4'd0,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd0,  1'b0, 1'b0, 2'd0, 1'b1, 8'hFF, 4'd1));
    // bad BAT restarts, then reinit coincident with an FA that must be dropped
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hFC, 4'd0,  1'b0, 1'b0, 2'd1, 1'b1, 8'hFF, 4'd1));
    vec.push_back(mk(1'b1, 1'b1, 8'hFA, 4'd0,  1'b0, 1'b0, 2'd0, 1'b1, 8'hFF, 4'd1));
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd2,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    vec.push_back(mk(1'b0, 1'b1, 8'hAA, 4'd3,  1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    push_id(2'd0);
    vec.push_back(mk(1'b0, 1'b1, 8'hFA, 4'd10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));

    // reset state
    repeat (3) step();
    chk("rst_state",  32'(state_dbg),  32'd0);
    chk("rst_stream", 32'(stream_en),  32'd0);
    chk("rst_error",  32'(init_error), 32'd0);
    chk("rst_retry",  32'(retry_cnt),  32'd0);
    chk("rst_wr",     32'(ps2.wr_ps2), 32'd0);
    chk("rst_din",    32'(ps2.din),    32'd0);
    chk("rst_no_wr",  32'(wr_log.size()), 32'd0);
    rst = 1'b1;
    expect_write("init", 8'hFF, 4'd1);

    for (int i = 0; i < vec.size(); i++) apply_step($sformatf("row%0d", i), vec[i]);

    // silent mouse: timeouts resend FF until retries run out
    pulse_reinit();
    expect_write("to_first", 8'hFF, 4'd1);
    for (int k = 1; k <= 3; k++) begin
      gap = 0;
      while (wr_log.size() <= wr_seen && gap < 300) begin step(); gap++; end
      chk($sformatf("to%0d_gap_ok", k), 32'(gap >= 99 && gap <= 103), 32'd1);
      expect_write($sformatf("to%0d", k), 8'hFF, 4'd1);
      chk($sformatf("to%0d_retry", k), 32'(retry_cnt), 32'(k));
    end
    n = 0;
    while (state_dbg !== 4'd11 && n < 200) begin step(); n++; end
    chk("err_state",  32'(state_dbg),  32'd11);
    chk("err_flag",   32'(init_error), 32'd1);
    chk("err_stream", 32'(stream_en),  32'd0);
    chk("err_retry",  32'(retry_cnt),  32'd3);
    repeat (150) step();
    chk("err_no_tx",  32'(wr_log.size()), 32'(wr_seen));
    chk("err_hold",   32'(state_dbg),  32'd11);

    // reinit out of ERROR, then again while the FF is still being shifted out
    pulse_reinit();
    chk("reerr_state", 32'(state_dbg),  32'd0);
    chk("reerr_error", 32'(init_error), 32'd0);
    chk("reerr_retry", 32'(retry_cnt),  32'd0);
    n = 0;
    while (wr_log.size() <= wr_seen && n < 50) begin step(); n++; end
    chk("mid_first_din", 32'(wr_log.size() > wr_seen ? wr_log[wr_seen] : 8'h00), 32'hFF);
    wr_seen = wr_log.size();
    pulse_reinit();
    chk("mid_state", 32'(state_dbg), 32'd0);
    expect_write("mid_resend", 8'hFF, 4'd1);
    apply_step("mid_ack", mk(1'b0, 1'b1, 8'hFA, 4'd2, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));
    apply_step("mid_bat", mk(1'b0, 1'b1, 8'hAA, 4'd3, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 4'd0));

    // asynchronous reset mid-sequence with a nonzero retry count and din
    apply_step("ar_bad_id", mk(1'b0, 1'b1, 8'h55, 4'd0, 1'b0, 1'b0, 2'd1, 1'b1, 8'hFF, 4'd1));
    apply_step("ar_ack", mk(1'b0, 1'b1, 8'hFA, 4'd2, 1'b0, 1'b0, 2'd1, 1'b0, 8'h00, 4'd0));
    #2;
    rst = 1'b0;
    #1;
    chk("ar_state",  32'(state_dbg),  32'd0);
    chk("ar_retry",  32'(retry_cnt),  32'd0);
    chk("ar_din",    32'(ps2.din),    32'd0);
    chk("ar_wr",     32'(ps2.wr_ps2), 32'd0);
    chk("ar_stream", 32'(stream_en),  32'd0);
    chk("ar_error",  32'(init_error), 32'd0);
    repeat (3) step();
    rst = 1'b1;
    expect_write("ar_restart", 8'hFF, 4'd1);

    chk("single_wr_strobe", 32'(dbl_wr),  32'd0);
    chk("din_stable",       32'(din_bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
